// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit.
// Holds the state codes, the control-word layout, the bus/PC/constant selector
// codes, the ALU function codes, the opcode constants and the branch-condition
// evaluator.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_BR2   = 3'd2,
        ST_HALT  = 3'd7
    } state_t;

    // Declared MSB first, so the packed value is the ControlWord bus directly.
    typedef struct packed {
        logic [2:0] cgs;
        logic [2:0] ns;
        logic       addr_sel;
        logic [1:0] ds;
        logic [1:0] ps;
        logic       pc_sel;
        logic       b_sel;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } ctrl_word_t;

    // Bit offsets of each field within the 40-bit ControlWord.
    localparam int CW_SB    = 0;
    localparam int CW_SA    = 5;
    localparam int CW_DA    = 10;
    localparam int CW_RW    = 15;
    localparam int CW_MW    = 16;
    localparam int CW_SIZE  = 17;
    localparam int CW_C0    = 19;
    localparam int CW_FS    = 20;
    localparam int CW_SL    = 25;
    localparam int CW_IL    = 26;
    localparam int CW_BSEL  = 27;
    localparam int CW_PCSEL = 28;
    localparam int CW_PS    = 29;
    localparam int CW_DS    = 31;
    localparam int CW_AS    = 33;
    localparam int CW_NS    = 34;
    localparam int CW_CGS   = 37;

    localparam logic [2:0] CGS_ALU_IMM = 3'd0;
    localparam logic [2:0] CGS_DT      = 3'd1;
    localparam logic [2:0] CGS_BR      = 3'd2;
    localparam logic [2:0] CGS_CB      = 3'd3;
    localparam logic [2:0] CGS_SHAMT   = 3'd4;

    localparam logic [1:0] DS_ALU = 2'b00;
    localparam logic [1:0] DS_B   = 2'b01;
    localparam logic [1:0] DS_PC  = 2'b10;
    localparam logic [1:0] DS_MEM = 2'b11;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;

    localparam logic [4:0] FS_AND = 5'h00;
    localparam logic [4:0] FS_ORR = 5'h04;
    localparam logic [4:0] FS_ADD = 5'h08;
    localparam logic [4:0] FS_SUB = 5'h09;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [7:0]  OP_BCOND = 8'h54;
    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;
    localparam logic [5:0]  OP_B     = 6'h05;

    // sr = {V,C,N,Z}. Conditions come in pairs where the odd code is the
    // inverse of the even one; 4'hE/4'hF both mean "always".
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] sr);
        logic v, c, n, z, base;
        {v, c, n, z} = sr;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) return 1'b1;
        return base ^ cond[0];
    endfunction

endpackage

// File: rtl/legv8_constant_gen.sv
// Immediate generator for the LEGv8 control unit.
// Ports: i_ir (instruction), i_cgs (constant select) -> o_constant (64-bit).
// Branch offsets are reduced by one word because the PC has already been
// advanced by 4 in FETCH when the branch is taken.
module legv8_constant_gen
    import legv8_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    input  logic [2:0]  i_cgs,
    output logic [63:0] o_constant
);

    logic w_unused;
    assign w_unused = ^{i_ir[31:26], i_ir[4:0]};

    always_comb begin
        o_constant = 64'h0;
        case (i_cgs)
            CGS_ALU_IMM: o_constant = {52'h0, i_ir[21:10]};
            CGS_DT:      o_constant = {{55{i_ir[20]}}, i_ir[20:12]};
            CGS_BR:      o_constant = {{38{i_ir[25]}}, i_ir[25:0]} - 64'd1;
            CGS_CB:      o_constant = {{45{i_ir[23]}}, i_ir[23:5]} - 64'd1;
            CGS_SHAMT:   o_constant = {58'h0, i_ir[15:10]};
            default:     o_constant = 64'h0;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer driving the datapath ControlWord and constant.
// Ports: clock/reset (async, active low); IR_in, current_status {V,C,N,Z},
// SR_in {V,C,N,Z} in; ControlWord (40b), constant (64b), state, halted and
// instr_count (retired instructions) out.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter logic HALT_ON_UNKNOWN = 1'b1,
    parameter int   COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            IR_in,
    input  logic [3:0]             current_status,
    input  logic [3:0]             SR_in,
    output logic [39:0]            ControlWord,
    output logic [63:0]            constant,
    output logic [2:0]             state,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    state_t                 r_state;
    logic                   r_zlatch;
    logic [COUNT_WIDTH-1:0] r_count;

    ctrl_word_t  w_cw;
    logic [63:0] w_const;
    logic        w_zl_load;
    logic        w_retire;
    logic [10:0] w_op11;
    logic [9:0]  w_op10;
    logic [7:0]  w_op8;
    logic [5:0]  w_op6;
    logic        w_unused;

    assign w_op11   = IR_in[31:21];
    assign w_op10   = IR_in[31:22];
    assign w_op8    = IR_in[31:24];
    assign w_op6    = IR_in[31:26];
    assign w_unused = ^current_status[3:1];

    always_comb begin
        w_cw      = '0;
        w_zl_load = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_cw.addr_sel = 1'b1;
                w_cw.ds       = DS_MEM;
                w_cw.size     = 2'b11;
                w_cw.il       = 1'b1;
                w_cw.ps       = PS_INC;
                w_cw.ns       = ST_EXEC;
            end
            ST_EXEC: begin
                w_cw.ns = ST_FETCH;
                if (w_op11 == OP_ADD || w_op11 == OP_SUB ||
                    w_op11 == OP_AND || w_op11 == OP_ORR) begin
                    w_cw.ds = DS_ALU;
                    w_cw.rw = 1'b1;
                    w_cw.da = IR_in[4:0];
                    w_cw.sa = IR_in[9:5];
                    w_cw.sb = IR_in[20:16];
                    if (w_op11 == OP_SUB) begin
                        w_cw.fs = FS_SUB;
                        w_cw.c0 = 1'b1;
                    end else if (w_op11 == OP_AND) begin
                        w_cw.fs = FS_AND;
                    end else if (w_op11 == OP_ORR) begin
                        w_cw.fs = FS_ORR;
                    end else begin
                        w_cw.fs = FS_ADD;
                    end
                end else if (w_op10 == OP_ADDI || w_op10 == OP_SUBI) begin
                    w_cw.ds    = DS_ALU;
                    w_cw.rw    = 1'b1;
                    w_cw.da    = IR_in[4:0];
                    w_cw.sa    = IR_in[9:5];
                    w_cw.sb    = IR_in[20:16];
                    w_cw.b_sel = 1'b1;
                    w_cw.cgs   = CGS_ALU_IMM;
                    w_cw.fs    = (w_op10 == OP_SUBI) ? FS_SUB : FS_ADD;
                    w_cw.c0    = (w_op10 == OP_SUBI);
                end else if (w_op11 == OP_LDUR) begin
                    w_cw.ds    = DS_MEM;
                    w_cw.size  = 2'b11;
                    w_cw.rw    = 1'b1;
                    w_cw.da    = IR_in[4:0];
                    w_cw.sa    = IR_in[9:5];
                    w_cw.b_sel = 1'b1;
                    w_cw.fs    = FS_ADD;
                    w_cw.cgs   = CGS_DT;
                end else if (w_op11 == OP_STUR) begin
                    w_cw.ds    = DS_B;
                    w_cw.mw    = 1'b1;
                    w_cw.size  = 2'b11;
                    w_cw.sa    = IR_in[9:5];
                    w_cw.sb    = IR_in[4:0];
                    w_cw.b_sel = 1'b1;
                    w_cw.fs    = FS_ADD;
                    w_cw.cgs   = CGS_DT;
                end else if (w_op6 == OP_B) begin
                    w_cw.ps  = PS_BR;
                    w_cw.cgs = CGS_BR;
                end else if (w_op8 == OP_BCOND) begin
                    w_cw.ps  = cond_true(IR_in[3:0], SR_in) ? PS_BR : PS_HOLD;
                    w_cw.cgs = CGS_CB;
                end else if (w_op8 == OP_CBZ || w_op8 == OP_CBNZ) begin
                    // Pass Rt through the ALU (X31 + Rt) so the live Z flag
                    // can be captured; the branch itself resolves in BR2.
                    w_cw.sa   = 5'd31;
                    w_cw.sb   = IR_in[4:0];
                    w_cw.fs   = FS_ADD;
                    w_cw.ns   = ST_BR2;
                    w_zl_load = 1'b1;
                end else begin
                    w_cw.ns = HALT_ON_UNKNOWN ? ST_HALT : ST_FETCH;
                end
            end
            ST_BR2: begin
                // IR[24] distinguishes CBNZ (1) from CBZ (0).
                w_cw.ps  = (IR_in[24] ? ~r_zlatch : r_zlatch) ? PS_BR : PS_HOLD;
                w_cw.cgs = CGS_CB;
                w_cw.ns  = ST_FETCH;
            end
            default: begin
                w_cw.ns = ST_HALT;
            end
        endcase
    end

    assign w_retire = (r_state != ST_FETCH) && (w_cw.ns == ST_FETCH);

    legv8_constant_gen u_const (
        .i_ir       (IR_in),
        .i_cgs      (w_cw.cgs),
        .o_constant (w_const)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_FETCH;
            r_zlatch <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= state_t'(w_cw.ns);
            if (w_zl_load) r_zlatch <= current_status[0];
            if (w_retire)  r_count  <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Outputs are forced quiet while reset is held so nothing is written.
    assign ControlWord = reset ? w_cw    : 40'h0;
    assign constant    = reset ? w_const : 64'h0;
    assign state       = r_state;
    assign halted      = (r_state == ST_HALT);
    assign instr_count = r_count;

endmodule
